// File: rtl/program_loader.sv
// program_loader: bus initiator that copies an external byte stream into
// program memory while holding the CPU in reset, keeping an 8-bit checksum.
// Optional read-back verification pass enabled by PROGRAM_LOADER_VERIFY_EN.
module program_loader #(
  parameter logic [7:0] LOAD_BASE = 8'h00,
  parameter logic [7:0] LOAD_LAST = 8'hDF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] length,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic [7:0] from_memory,
  output logic [7:0] to_memory,
  output logic [7:0] address,
  output logic       write,
  output logic       cpu_reset,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] checksum
);

  // 9 bits so a window covering the full 8-bit space does not overflow
  localparam logic [8:0] CAPACITY = {1'b0, LOAD_LAST} - {1'b0, LOAD_BASE} + 9'd1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
`ifdef PROGRAM_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE,
    ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] address_q, address_d;
  logic [7:0] to_memory_q, to_memory_d;
  logic       write_q, write_d;
  logic       byte_ready_q, byte_ready_d;
  logic       cpu_reset_q, cpu_reset_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;
  logic [7:0] checksum_q, checksum_d;
  logic [7:0] index_q, index_d;
  logic [7:0] len_q, len_d;
`ifdef PROGRAM_LOADER_VERIFY_EN
  logic [7:0] vcnt_q, vcnt_d;
  logic [7:0] vsum_q, vsum_d;
`else
  logic       unused_from_memory;
  assign unused_from_memory = ^from_memory;
`endif

  // State and registered-output update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      address_q    <= LOAD_BASE;
      to_memory_q  <= '0;
      write_q      <= 1'b0;
      byte_ready_q <= 1'b0;
      cpu_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      checksum_q   <= '0;
      index_q      <= '0;
      len_q        <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
      vcnt_q       <= '0;
      vsum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      to_memory_q  <= to_memory_d;
      write_q      <= write_d;
      byte_ready_q <= byte_ready_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      checksum_q   <= checksum_d;
      index_q      <= index_d;
      len_q        <= len_d;
`ifdef PROGRAM_LOADER_VERIFY_EN
      vcnt_q       <= vcnt_d;
      vsum_q       <= vsum_d;
`endif
    end
  end

  // Next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    to_memory_d  = to_memory_q;
    write_d      = 1'b0;
    byte_ready_d = byte_ready_q;
    cpu_reset_d  = cpu_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    checksum_d   = checksum_q;
    index_d      = index_q;
    len_d        = len_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
    vcnt_d       = vcnt_q;
    vsum_d       = vsum_q;
`endif
    case (state_q)
      LOAD: begin
        // index == len means this is the write cycle of the final byte
        if (index_q == len_q) begin
          byte_ready_d = 1'b0;
`ifdef PROGRAM_LOADER_VERIFY_EN
          state_d   = VERIFY;
          address_d = LOAD_BASE;
          vcnt_d    = '0;
          vsum_d    = '0;
`else
          state_d     = DONE;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
          address_d   = LOAD_BASE;
`endif
        end else if (byte_valid && byte_ready_q) begin
          address_d   = LOAD_BASE + index_q;
          to_memory_d = byte_in;
          write_d     = 1'b1;
          checksum_d  = checksum_q + byte_in;
          index_d     = index_q + 8'd1;
          if (index_q + 8'd1 == len_q) byte_ready_d = 1'b0;
        end
      end
`ifdef PROGRAM_LOADER_VERIFY_EN
      VERIFY: begin
        // read data lags its address by one cycle, so cycle k sums address k-1
        if (vcnt_q != '0) vsum_d = vsum_q + from_memory;
        if (vcnt_q == len_q) begin
          busy_d      = 1'b0;
          cpu_reset_d = 1'b0;
          address_d   = LOAD_BASE;
          if (vsum_q + from_memory == checksum_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERROR;
            error_d = 1'b1;
          end
        end else begin
          vcnt_d = vcnt_q + 8'd1;
          if (vcnt_q + 8'd1 < len_q) address_d = LOAD_BASE + vcnt_q + 8'd1;
        end
      end
`endif
      default: begin
        if (start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          checksum_d = '0;
          index_d    = '0;
          len_d      = length;
          address_d  = LOAD_BASE;
          if (length == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if ({1'b0, length} > CAPACITY) begin
            state_d = ERROR;
            error_d = 1'b1;
          end else begin
            state_d      = LOAD;
            busy_d       = 1'b1;
            cpu_reset_d  = 1'b1;
            byte_ready_d = 1'b1;
          end
        end
      end
    endcase
  end

  assign byte_ready = byte_ready_q;
  assign to_memory  = to_memory_q;
  assign address    = address_q;
  assign write      = write_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: directed and randomized loads checked against
// a simple image/checksum model and a synchronous-read memory model.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] length = '0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic [7:0] from_memory = '0;
  logic [7:0] to_memory;
  logic [7:0] address;
  logic       write;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] checksum;

`ifdef PROGRAM_LOADER_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif
  localparam int CAP = 224;

  program_loader #(.LOAD_BASE(8'h00), .LOAD_LAST(8'hDF)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .from_memory(from_memory), .to_memory(to_memory), .address(address),
    .write(write), .cpu_reset(cpu_reset), .busy(busy), .done(done),
    .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [7:0] mem  [256];
  logic [7:0] stim [256];
  bit corrupt = 1'b0;

  // memory with synchronous read; optional corruption of address 02
  always @(posedge clk) begin
    if (write) mem[address] <= (corrupt && address == 8'h02) ? (to_memory ^ 8'h5A) : to_memory;
    from_memory <= mem[address];
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int viol = 0;
  int rdy_cnt = 0;
  int done_cyc = -1;
  bit done_prev = 1'b0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];
  int wc[$];

  // bus monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (write) begin
      wa.push_back(address);
      wd.push_back(to_memory);
      wc.push_back(cyc);
    end
    if (write && !busy) viol++;
    if (address > 8'hDF) viol++;
    if (cpu_reset !== busy) viol++;
    if (byte_ready) rdy_cnt++;
    if (done && !done_prev) done_cyc = cyc;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_address"}, address, 8'h00);
    chk({p, "_to_memory"}, to_memory, 8'h00);
    chk({p, "_write"}, write, 0);
    chk({p, "_byte_ready"}, byte_ready, 0);
    chk({p, "_cpu_reset"}, cpu_reset, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_error"}, error, 0);
    chk({p, "_checksum"}, checksum, 8'h00);
  endtask

  // run one load from the current negedge; stim[] holds the image
  task automatic do_load(input int len, input int gap, input bit use_mask,
                         input logic [31:0] vmask, input bit bad_mem);
    int k, c, sum, nexp, last;
    bit acc, tmo, exp_err;
    wa.delete(); wd.delete(); wc.delete();
    rdy_cnt = 0;
    done_cyc = -1;
    start = 1'b1;
    length = len[7:0];
    @(negedge clk);
    start = 1'b0;
    k = 0; c = 0; tmo = 1'b0;
    while (!(done || error)) begin
      if (c >= 3000) begin tmo = 1'b1; break; end
      if (k < len) begin
        byte_valid = use_mask ? vmask[c[4:0]] : ($urandom_range(99) >= gap);
        byte_in = stim[k];
      end else begin
        byte_valid = 1'b1;
        byte_in = 8'($urandom);
      end
      acc = byte_valid && byte_ready;
      @(negedge clk);
      if (acc) k++;
      c++;
    end
    byte_valid = 1'b0;
    @(negedge clk);

    exp_err = (len > CAP) || bad_mem;
    nexp = (len > CAP) ? 0 : len;
    sum = 0;
    for (int i = 0; i < nexp; i++) sum += stim[i];
    sum = sum % 256;

    chk("timeout", tmo, 0);
    chk("done", done, exp_err ? 0 : 1);
    chk("error", error, exp_err ? 1 : 0);
    if (!bad_mem) chk("checksum", checksum, sum);
    chk("nwrites", wa.size(), nexp);
    for (int i = 0; i < wa.size() && i < nexp; i++) begin
      chk("wr_addr", wa[i], i);
      chk("wr_data", wd[i], stim[i]);
      if (!bad_mem) chk("mem", mem[i], stim[i]);
    end
    if (len > CAP) chk("rdy_never", rdy_cnt, 0);
    last = wc.size() - 1;
    if (nexp > 0 && !exp_err && last >= 0)
      chk("done_lat", done_cyc - wc[last], 1 + VER * (len + 1));
    if (!use_mask && gap == 0 && nexp > 1 && last >= 0)
      chk("b2b", wc[last] - wc[0], nexp - 1);
    chk("busy_end", busy, 0);
    chk("cpurst_end", cpu_reset, 0);
    chk("addr_end", address, 8'h00);
    chk("write_end", write, 0);
    chk("invariants", viol, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    reset = 1'b0;
    @(negedge clk);

    // three bytes back-to-back
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    do_load(3, 0, 1'b0, '0, 1'b0);
    chk("tp1_sum", checksum, 8'h66);

    // two bytes with a two-cycle gap; checksum wraps
    stim[0] = 8'hF0; stim[1] = 8'h20;
    do_load(2, 0, 1'b1, 32'b1001, 1'b0);
    chk("tp2_sum", checksum, 8'h10);
    if (wc.size() == 2) chk("tp2_gap", wc[1] - wc[0], 3);

    // zero length
    do_load(0, 0, 1'b0, '0, 1'b0);

    // oversize, then a normal single-byte load clears the error
    do_load(225, 0, 1'b0, '0, 1'b0);
    stim[0] = 8'($urandom);
    do_load(1, 0, 1'b0, '0, 1'b0);

    // reset after two of four bytes
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    wa.delete(); wd.delete(); wc.delete();
    start = 1'b1; length = 8'd4;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_in = stim[0];
    @(negedge clk);
    byte_in = stim[1];
    @(negedge clk);
    byte_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_nwr", wa.size(), 2);
    chk("midrst_mem0", mem[0], stim[0]);
    chk("midrst_mem1", mem[1], stim[1]);
    @(negedge clk);

    // randomized loads
    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) stim[i] = 8'($urandom);
      do_load(len, $urandom_range(0, 60), 1'b0, '0, 1'b0);
    end

    // largest legal image reaches LOAD_LAST
    for (int i = 0; i < CAP; i++) stim[i] = 8'($urandom);
    do_load(CAP, 0, 1'b0, '0, 1'b0);
    if (wa.size() == CAP) chk("last_addr", wa[CAP-1], 8'hDF);

`ifdef PROGRAM_LOADER_VERIFY_EN
    for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
    do_load(4, 0, 1'b0, '0, 1'b0);
    corrupt = 1'b1;
    do_load(4, 0, 1'b0, '0, 1'b1);
    corrupt = 1'b0;
    do_load(4, 20, 1'b0, '0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
